// File: rtl/mcu_scheduler_if.sv
// Scheduler bus: frame configuration, block-completion input and the
// control outputs steering the entropy decoder and input buffer.
interface mcu_scheduler_if #(
  parameter int unsigned MCU_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_mode;
  logic [MCU_W-1:0] cfg_mcu_total;
  logic [MCU_W-1:0] cfg_restart_int;
  logic             block_done;
  logic             decode_en;
  logic [1:0]       ch;
  logic [2:0]       blk_idx;
  logic [MCU_W-1:0] mcu_cnt;
  logic             dc_clear;
  logic             restart_req;
  logic             restart_ack;
  logic             frame_done;
  logic             err;

  // Driver side: supplies config, block pulses and marker acks.
  modport master (
    output cfg_valid, cfg_mode, cfg_mcu_total, cfg_restart_int, block_done, restart_ack,
    input  cfg_ready, decode_en, ch, blk_idx, mcu_cnt, dc_clear, restart_req, frame_done, err
  );

  // Scheduler side.
  modport slave (
    input  cfg_valid, cfg_mode, cfg_mcu_total, cfg_restart_int, block_done, restart_ack,
    output cfg_ready, decode_en, ch, blk_idx, mcu_cnt, dc_clear, restart_req, frame_done, err
  );
endinterface

// File: rtl/mcu_scheduler.sv
// MCU scheduler: walks the block order of each MCU for 4:4:4, 4:2:2, 4:2:0
// and grayscale, counts MCUs, and pauses at restart-interval boundaries
// until the input buffer has consumed the RSTn marker.
module mcu_scheduler #(
  parameter int unsigned MCU_W = 16
) (
  input logic             clk,
  input logic             rst,
  mcu_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StRestart, StDone} state_e;

  state_e           state_q;
  logic [1:0]       mode_q;
  logic [MCU_W-1:0] total_q;
  logic [MCU_W-1:0] rint_q;
  logic [MCU_W-1:0] intv_q;
  logic [MCU_W-1:0] mcu_q;
  logic [2:0]       blk_q;
  logic [1:0]       ch_q;
  logic             decode_en_q;
  logic             dc_clear_q;
  logic             restart_req_q;
  logic             frame_done_q;
  logic             err_q;

  logic [2:0]       blk_last;
  logic [2:0]       blk_nxt;
  logic [1:0]       ch_nxt;
  logic [MCU_W-1:0] mcu_inc;
  logic [MCU_W-1:0] intv_inc;
  logic             last_blk;

  // Per-mode block geometry and the channel of the block that follows.
  always_comb begin
    unique case (mode_q)
      2'd0:    blk_last = 3'd2;
      2'd1:    blk_last = 3'd3;
      2'd2:    blk_last = 3'd5;
      default: blk_last = 3'd0;
    endcase
    blk_nxt  = blk_q + 3'd1;
    last_blk = (blk_q == blk_last);
    // The final two slots of a colour MCU are Cb then Cr; all earlier slots are Y.
    ch_nxt = 2'd0;
    if (mode_q != 2'd3) begin
      if (blk_nxt == blk_last) begin
        ch_nxt = 2'd2;
      end else if (blk_nxt == blk_last - 3'd1) begin
        ch_nxt = 2'd1;
      end
    end
    mcu_inc  = (mcu_q == {MCU_W{1'b1}}) ? mcu_q : mcu_q + MCU_W'(1);
    intv_inc = intv_q + MCU_W'(1);
  end

  // Scheduler FSM with all counters and control outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      mode_q        <= 2'd0;
      total_q       <= '0;
      rint_q        <= '0;
      intv_q        <= '0;
      mcu_q         <= '0;
      blk_q         <= 3'd0;
      ch_q          <= 2'd0;
      decode_en_q   <= 1'b0;
      dc_clear_q    <= 1'b0;
      restart_req_q <= 1'b0;
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      dc_clear_q   <= 1'b0;
      frame_done_q <= 1'b0;
      if (bus.block_done && (state_q != StRun)) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (bus.cfg_valid) begin
            mode_q  <= bus.cfg_mode;
            total_q <= bus.cfg_mcu_total;
            rint_q  <= bus.cfg_restart_int;
            intv_q  <= '0;
            mcu_q   <= '0;
            blk_q   <= 3'd0;
            ch_q    <= 2'd0;
            err_q   <= 1'b0;
            if (bus.cfg_mcu_total == '0) begin
              // Empty frame completes immediately without touching the predictors.
              state_q      <= StDone;
              frame_done_q <= 1'b1;
            end else begin
              state_q     <= StRun;
              decode_en_q <= 1'b1;
              dc_clear_q  <= 1'b1;
            end
          end
        end
        StRun: begin
          if (bus.block_done) begin
            if (last_blk) begin
              blk_q <= 3'd0;
              ch_q  <= 2'd0;
              mcu_q <= mcu_inc;
              // Frame end wins over a restart boundary on the same MCU.
              if (mcu_inc == total_q) begin
                state_q      <= StDone;
                decode_en_q  <= 1'b0;
                frame_done_q <= 1'b1;
              end else if ((rint_q != '0) && (intv_inc == rint_q)) begin
                state_q       <= StRestart;
                decode_en_q   <= 1'b0;
                restart_req_q <= 1'b1;
                intv_q        <= '0;
              end else begin
                intv_q <= intv_inc;
              end
            end else begin
              blk_q <= blk_nxt;
              ch_q  <= ch_nxt;
            end
          end
        end
        StRestart: begin
          if (bus.restart_ack) begin
            state_q       <= StRun;
            restart_req_q <= 1'b0;
            dc_clear_q    <= 1'b1;
            decode_en_q   <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.cfg_ready   = (state_q == StIdle) & rst;
  assign bus.decode_en   = decode_en_q;
  assign bus.ch          = ch_q;
  assign bus.blk_idx     = blk_q;
  assign bus.mcu_cnt     = mcu_q;
  assign bus.dc_clear    = dc_clear_q;
  assign bus.restart_req = restart_req_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_mcu_scheduler.sv
// Bench for mcu_scheduler: directed frames from the test plan plus random
// frames, checked against a block-count model of the MCU/restart rules.
module tb_mcu_scheduler;

  localparam int unsigned MCU_W = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mcu_scheduler_if #(.MCU_W(MCU_W)) bus ();

  mcu_scheduler #(.MCU_W(MCU_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_err  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int nblk_of(input int mode);
    case (mode)
      0:       return 3;
      1:       return 4;
      2:       return 6;
      default: return 1;
    endcase
  endfunction

  // Channel of slot idx: Y slots, then Cb, then Cr (gray is a single Y).
  function automatic int ch_at(input int mode, input int idx);
    int q[$];
    int ny;
    ny = (mode == 3) ? 1 : nblk_of(mode) - 2;
    for (int i = 0; i < ny; i++) q.push_back(0);
    if (mode != 3) begin
      q.push_back(1);
      q.push_back(2);
    end
    return q[idx];
  endfunction

  task automatic accept(input int mode, input int total, input int rint);
    bus.cfg_valid       = 1'b1;
    bus.cfg_mode        = 2'(mode);
    bus.cfg_mcu_total   = MCU_W'(total);
    bus.cfg_restart_int = MCU_W'(rint);
    tick();
    bus.cfg_valid = 1'b0;
    exp_err       = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dec"}, bus.decode_en, 0);
    check({tag, "_ch"}, bus.ch, 0);
    check({tag, "_blk"}, bus.blk_idx, 0);
    check({tag, "_mcu"}, bus.mcu_cnt, 0);
    check({tag, "_clr"}, bus.dc_clear, 0);
    check({tag, "_rreq"}, bus.restart_req, 0);
    check({tag, "_fd"}, bus.frame_done, 0);
    check({tag, "_err"}, bus.err, 0);
    check({tag, "_rdy"}, bus.cfg_ready, 0);
  endtask

  // gap < 0 selects a random 0..2 idle cycles before each block pulse.
  task automatic run_frame(input int mode, input int total, input int rint, input int gap,
                           input int ack_dly, input bit inj);
    int nb;
    int done_blks;
    int m;
    int g;
    nb = nblk_of(mode);
    check("idle_ready", bus.cfg_ready, 1);
    accept(mode, total, rint);
    if (total == 0) begin
      check("empty_fd", bus.frame_done, 1);
      check("empty_clr", bus.dc_clear, 0);
      check("empty_dec", bus.decode_en, 0);
      check("empty_err", bus.err, 0);
      tick();
      check("empty_rdy", bus.cfg_ready, 1);
      check("empty_fd_off", bus.frame_done, 0);
      return;
    end
    check("start_dec", bus.decode_en, 1);
    check("start_clr", bus.dc_clear, 1);
    check("start_ch", bus.ch, 0);
    check("start_mcu", bus.mcu_cnt, 0);
    check("start_err", bus.err, 0);
    check("start_rdy", bus.cfg_ready, 0);
    for (int k = 0; k < total * nb; k++) begin
      g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
      repeat (g) begin
        tick();
        check("gap_dec", bus.decode_en, 1);
        check("gap_clr", bus.dc_clear, 0);
      end
      bus.block_done = 1'b1;
      tick();
      bus.block_done = 1'b0;
      done_blks = k + 1;
      m = done_blks / nb;
      check("blk_idx", bus.blk_idx, done_blks % nb);
      check("ch", bus.ch, ch_at(mode, done_blks % nb));
      check("mcu_cnt", bus.mcu_cnt, m);
      check("blk_clr", bus.dc_clear, 0);
      check("blk_err", bus.err, exp_err);
      if ((done_blks % nb == 0) && (m == total)) begin
        check("end_fd", bus.frame_done, 1);
        check("end_dec", bus.decode_en, 0);
        check("end_rreq", bus.restart_req, 0);
        tick();
        check("end_rdy", bus.cfg_ready, 1);
        check("end_fd_off", bus.frame_done, 0);
      end else if ((done_blks % nb == 0) && (rint != 0) && (m % rint == 0)) begin
        check("rst_req", bus.restart_req, 1);
        check("rst_dec", bus.decode_en, 0);
        check("rst_fd", bus.frame_done, 0);
        for (int d = 0; d < ack_dly; d++) begin
          if (inj && d == 0) bus.block_done = 1'b1;
          tick();
          bus.block_done = 1'b0;
          if (inj && d == 0) exp_err = 1'b1;
          check("rwait_req", bus.restart_req, 1);
          check("rwait_dec", bus.decode_en, 0);
          check("rwait_blk", bus.blk_idx, 0);
          check("rwait_mcu", bus.mcu_cnt, m);
          check("rwait_err", bus.err, exp_err);
        end
        bus.restart_ack = 1'b1;
        tick();
        bus.restart_ack = 1'b0;
        check("ack_req", bus.restart_req, 0);
        check("ack_clr", bus.dc_clear, 1);
        check("ack_dec", bus.decode_en, 1);
        check("ack_ch", bus.ch, 0);
      end else begin
        check("run_dec", bus.decode_en, 1);
        check("run_rreq", bus.restart_req, 0);
        check("run_fd", bus.frame_done, 0);
      end
    end
  endtask

  initial begin
    bus.cfg_valid       = 1'b0;
    bus.cfg_mode        = 2'd0;
    bus.cfg_mcu_total   = '0;
    bus.cfg_restart_int = '0;
    bus.block_done      = 1'b0;
    bus.restart_ack     = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    check_all_zero("por");
    rst = 1'b1;
    tick();

    // 4:2:0, two MCUs, no restarts, pulses two cycles apart.
    run_frame(2, 2, 0, 1, 0, 1'b0);
    // 4:2:2, four MCUs, restart every two, back-to-back blocks.
    run_frame(1, 4, 2, 0, 4, 1'b0);
    // Gray, restart after every MCU.
    run_frame(3, 3, 1, -1, 2, 1'b0);

    // Stray block in IDLE flags err and leaves counters alone.
    bus.block_done = 1'b1;
    tick();
    bus.block_done = 1'b0;
    check("idle_err", bus.err, 1);
    check("idle_mcu", bus.mcu_cnt, 3);
    check("idle_blk", bus.blk_idx, 0);
    check("idle_rdy", bus.cfg_ready, 1);

    // Empty frame; the accept also clears the sticky err.
    run_frame(0, 0, 0, 0, 0, 1'b0);
    // Stray block while waiting for the restart ack.
    run_frame(1, 3, 1, 0, 3, 1'b1);

    // Mid-frame reset in 4:4:4 after one MCU.
    accept(0, 3, 0);
    for (int i = 0; i < 3; i++) begin
      bus.block_done = 1'b1;
      tick();
    end
    bus.block_done = 1'b0;
    check("pre_rst_mcu", bus.mcu_cnt, 1);
    rst = 1'b0;
    tick();
    check_all_zero("mid_rst");
    tick();
    check("mid_rst_fd", bus.frame_done, 0);
    rst = 1'b1;
    tick();
    run_frame(0, 2, 0, -1, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      run_frame(int'($urandom_range(3, 0)), int'($urandom_range(5, 0)),
                int'($urandom_range(3, 0)), -1, int'($urandom_range(4, 1)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mcu_scheduler.md
# mcu_scheduler

Sequences the entropy decoder through the block order of each MCU and through restart intervals. It replaces the fixed Y‑Y‑Y‑Y‑Cb‑Cr channel counter with a configurable scheduler covering 4:4:4, 4:2:2, 4:2:0 and grayscale. It sits beside the entropy decoder:
- consumes the block-buffer completion pulse;
- drives the channel select to the Huffman, diff and dequant stages;
- clears the DC predictors;
- handshakes with the input buffer around RSTn markers.

## Interface
- Parameters:
- `MCU_W`, 16, width of MCU count and restart-interval fields
- Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-low reset (asserted when 0)
- `cfg_valid`  in  1  frame configuration present
- `cfg_ready`  out  1  scheduler idle, config accepted when `cfg_valid & cfg_ready`
- `cfg_mode`  in  2  0 = 4:4:4 (Y Cb Cr), 1 = 4:2:2 (Y Y Cb Cr), 2 = 4:2:0 (Y Y Y Y Cb Cr), 3 = gray (Y)
- `cfg_mcu_total`  in  MCU_W  MCUs in frame
- `cfg_restart_int`  in  MCU_W  MCUs per restart interval; 0 = no restarts
- `block_done`  in  1  one-cycle pulse, block emitted by block buffer
- `decode_en`  out  1  entropy decoding permitted
- `ch`  out  2  channel of current block: 0 = Y, 1 = Cb, 2 = Cr
- `blk_idx`  out  3  block index within current MCU
- `mcu_cnt`  out  MCU_W  MCUs completed in frame
- `dc_clear`  out  1  one-cycle pulse, zero all DC predictors
- `restart_req`  out  1  level, input buffer must consume RSTn marker and realign
- `restart_ack`  in  1  pulse, marker consumed
- `frame_done`  out  1  one-cycle pulse, last MCU completed
- `err`  out  1  sticky, `block_done` seen outside RUN; cleared only by reset or config accept

## Operation
- States: IDLE, RUN, RESTART, DONE.
- Block count per MCU (`nblk`): 3, 4, 6, 1 for modes 0–3.
- Block order: Y blocks first (`nblk` − 2 of them, or 1 for gray), then Cb, then Cr.
- Config and counters are latched on accept; inputs are ignored while `cfg_ready` = 0.
- IDLE:
  - `cfg_ready` = 1.
  - On accept: latch config, set `blk_idx` = 0, `mcu_cnt` = 0, interval counter = 0.
  - Pulse `dc_clear`, go to RUN.
  - If `cfg_mcu_total` = 0, go to DONE instead (no `dc_clear`).
- RUN:
  - `decode_en` = 1.
  - On `block_done`: `blk_idx` increments.
  - At `blk_idx` = `nblk` − 1: `blk_idx` → 0, `mcu_cnt` +1, interval counter +1.
  - If new `mcu_cnt` == total → DONE.
  - Else if `cfg_restart_int` ≠ 0 and new interval count == `cfg_restart_int` → RESTART, and the interval counter clears.
  - DONE has priority over RESTART when both fall on the same MCU.
- RESTART:
  - `decode_en` = 0, `restart_req` = 1.
  - On `restart_ack`: pulse `dc_clear`, drop `restart_req`, return to RUN.
  - `blk_idx` = 0, `ch` = 0.
- DONE:
  - Pulse `frame_done` for one cycle, go to IDLE next cycle.
- `block_done` in IDLE, RESTART or DONE: ignored for counting, sets `err`.
- `restart_ack` outside RESTART: ignored.
- `mcu_cnt` saturates at all-ones and never wraps, since total ≤ all-ones.

## Timing
- All state, counters and pulse outputs are registered.
- `cfg_ready` = (state == IDLE) & `rst`, combinational.
- Reset (rst = 0):
  - Next edge forces IDLE.
  - All outputs 0, including `err`.
  - `cfg_ready` is 0 while `rst` = 0 and rises the first cycle after release.
  - Mid-frame reset abandons the frame with no `frame_done`.
- Config accept at edge N:
  - `decode_en` = 1, `dc_clear` = 1, `ch` = 0 during cycle N+1.
  - `dc_clear` = 0 from N+2.
- `block_done` sampled at edge N → `ch`, `blk_idx`, `mcu_cnt` updated in cycle N+1.
  - This covers a back-to-back `block_done` every cycle.
- Last block → `decode_en` falls in cycle N+1.
  - Restart case: `restart_req` rises in cycle N+1.
  - Done case: `frame_done` = 1 in cycle N+1, `cfg_ready` = 1 in cycle N+2.
- `restart_ack` at edge M:
  - `restart_req` = 0, `dc_clear` = 1, `decode_en` = 1 in cycle M+1.
  - `restart_ack` coincident with the entry edge is not seen; the ack must arrive after `restart_req` is observed high.
- `block_done` and config accept can never coincide, since they are legal in distinct states.

## Test plan
- Mode 2, total = 2, restart = 0, 12 `block_done` pulses 2 cycles apart:
  - `ch` sequence 0,0,0,0,1,2,0,0,0,0,1,2.
  - `mcu_cnt` 1 then 2.
  - One `frame_done` cycle after the 12th pulse; `dc_clear` only once, at start.
- Mode 1, total = 4, restart = 2, back-to-back `block_done`:
  - `restart_req` rises after the 8th block; `decode_en` = 0 while it is high.
  - `restart_ack` 5 cycles later → `dc_clear` pulse, RUN resumes with `ch` = 0.
  - No restart after MCU 4 (DONE priority); `frame_done` follows the 16th block.
- Mode 3, total = 3, restart = 1:
  - `ch` constant 0.
  - Two restart handshakes, then `frame_done`.
  - `err` stays 0.
- `cfg_mcu_total` = 0:
  - `frame_done` in cycle after accept, no `dc_clear`.
  - `cfg_ready` high the following cycle.
- Error case: `block_done` in IDLE and in RESTART → `err` = 1 and counters unchanged; next config accept clears `err`.
- Reset case: rst = 0 mid-frame at `mcu_cnt` = 1 in mode 0:
  - All outputs 0 next cycle, no `frame_done`.
  - After release a new config is accepted and restarts from `mcu_cnt` = 0.
